uart_tx: RTL

Serial UART transmitter for the system's UART block: takes a parallel byte with a valid strobe and serialises it LSB-first as start, data, optional parity and stop bits. It pairs with the UART receiver and runs on the UART TX clock domain at one bit per `CLK` cycle, so `CLK` is the baud-rate clock. `BUSY` is the back-pressure signal to the upstream FIFO reader.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_if.sv | 27 ++
 rtl/uart_tx_parity_calc.sv | 15 +
 rtl/uart_tx.sv | 106 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type codes, default frame width.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Upstream request / serial line bundle for the UART transmitter.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  // Upstream side: issues requests, observes back-pressure and line.
  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, BUSY
  );

  // Transmitter side.
  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, BUSY
  );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of the latched frame data.
module parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity_c
);

  // Even parity is the XOR of all bits; odd parity inverts it.
  assign parity_c = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit, one bit per clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  localparam int unsigned      CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic                  tx_out;
  logic                  busy;
  logic                  parity_c;
  logic                  accept_c;

  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data     (data_reg),
    .par_typ  (par_typ_reg),
    .parity_c (parity_c)
  );

  // Requests are only taken when idle or on the stop bit (back-to-back).
  assign accept_c = bus.DATA_VALID && ((state == ST_IDLE) || (state == ST_STOP));

  // Frame FSM with registered line and busy outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      data_reg    <= '0;
      shreg       <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      tx_out      <= 1'b1;
      busy        <= 1'b0;
    end else if (accept_c) begin
      data_reg    <= bus.P_DATA;
      shreg       <= bus.P_DATA;
      par_en_reg  <= bus.PAR_EN;
      par_typ_reg <= bus.PAR_TYP;
      state       <= ST_START;
      tx_out      <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
        ST_START: begin
          tx_out <= shreg[0];
          shreg  <= shreg >> 1;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= ST_DATA;
        end
        ST_DATA: begin
          busy <= 1'b1;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (par_en_reg) begin
              tx_out <= parity_c;
              state  <= ST_PARITY;
            end else begin
              tx_out <= 1'b1;
              state  <= ST_STOP;
            end
          end else begin
            cnt    <= cnt + CNT_W'(1);
            tx_out <= shreg[0];
            shreg  <= shreg >> 1;
          end
        end
        ST_PARITY: begin
          tx_out <= 1'b1;
          busy   <= 1'b1;
          state  <= ST_STOP;
        end
        ST_STOP: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_out;
  assign bus.BUSY   = busy;

endmodule
